mtm_alu_serializer: RTL and testbench

MTM_ALU_SERIALIZER -- requirements
Module: mtm_alu_serializer

---
 rtl/mtm_alu_serializer.sv | 133 +++++++++++++
 tb/tb_mtm_alu_serializer.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mtm_alu_serializer.sv
// Serializer for MTM ALU results: packs a 32-bit result plus control byte into 11-bit UART-like frames.
// Optional build macro MTM_SER_CRC_REGEN_EN regenerates the CRC3 field of result CTL frames at capture.
module mtm_alu_serializer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] C,
  input  logic [7:0]  CTL_in,
  input  logic        in_valid,
  output logic        in_ready,
  output logic        sout,
  output logic        busy
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_TYPE  = 3'd2;
  localparam logic [2:0] S_DATA  = 3'd3;
  localparam logic [2:0] S_STOP  = 3'd4;

  // Frame index 4 is always the CTL frame; error packets start there directly.
  localparam logic [2:0] CTL_FRAME = 3'd4;

  logic [2:0]  state;
  logic [2:0]  frame_cnt;
  logic [2:0]  bit_cnt;
  logic [31:0] c_q;
  logic [7:0]  ctl_q;
  logic [7:0]  ctl_cap;
  logic [7:0]  cur_byte;

`ifdef MTM_SER_CRC_REGEN_EN
  // CRC3, polynomial x^3+x+1, init 000, message shifted in MSB first.
  function automatic logic [2:0] crc3(input logic [36:0] d);
    logic [2:0] r;
    logic       fb;
    // NOTE: blocking assignments are correct here: this is a combinational
    // loop unrolled at elaboration, each step reading the previous one.
    r = 3'b000;
    for (int i = 36; i >= 0; i--) begin
      fb = r[2] ^ d[i];
      r  = {r[1], r[0] ^ fb, fb};
    end
    return r;
  endfunction

  always_comb begin
    // NOTE: default assignment first so no path leaves ctl_cap unassigned (no latch).
    ctl_cap = CTL_in;
    if (!CTL_in[7]) begin
      ctl_cap = {CTL_in[7:3], crc3({C, 1'b0, CTL_in[6:3]})};
    end
  end
`else
  always_comb begin
    ctl_cap = CTL_in;
  end
`endif

  always_comb begin
    cur_byte = ctl_q;
    case (frame_cnt)
      3'd0:    cur_byte = c_q[31:24];
      3'd1:    cur_byte = c_q[23:16];
      3'd2:    cur_byte = c_q[15:8];
      3'd3:    cur_byte = c_q[7:0];
      default: cur_byte = ctl_q;
    endcase
  end

  assign in_ready = (state == S_IDLE);
  assign busy     = ~in_ready;

  // sout is registered: each transition loads the bit belonging to the state being entered.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // NOTE: captured data registers are reset too, so a fresh part never
      // carries stale packet contents; this is a handful of flops, not a memory.
      state     <= S_IDLE;
      sout      <= 1'b1;
      frame_cnt <= 3'd0;
      bit_cnt   <= 3'd0;
      c_q       <= 32'd0;
      ctl_q     <= 8'd0;
    end else begin
      case (state)
        S_IDLE: begin
          sout <= 1'b1;
          if (in_valid) begin
            c_q       <= C;
            ctl_q     <= ctl_cap;
            frame_cnt <= CTL_in[7] ? CTL_FRAME : 3'd0;
            state     <= S_START;
            sout      <= 1'b0;
          end
        end
        S_START: begin
          state <= S_TYPE;
          sout  <= (frame_cnt == CTL_FRAME);
        end
        S_TYPE: begin
          state   <= S_DATA;
          bit_cnt <= 3'd7;
          sout    <= cur_byte[7];
        end
        S_DATA: begin
          if (bit_cnt == 3'd0) begin
            state <= S_STOP;
            sout  <= 1'b1;
          end else begin
            bit_cnt <= bit_cnt - 3'd1;
            sout    <= cur_byte[bit_cnt - 3'd1];
          end
        end
        S_STOP: begin
          if (frame_cnt == CTL_FRAME) begin
            state     <= S_IDLE;
            frame_cnt <= 3'd0;
            sout      <= 1'b1;
          end else begin
            frame_cnt <= frame_cnt + 3'd1;
            state     <= S_START;
            sout      <= 1'b0;
          end
        end
        default: begin
          state <= S_IDLE;
          sout  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mtm_alu_serializer.sv
// Directed self-checking bench for mtm_alu_serializer; outputs are sampled on the falling edge.
module tb_mtm_alu_serializer;

  logic        clk;
  logic        rst_n;
  logic [31:0] C;
  logic [7:0]  CTL_in;
  logic        in_valid;
  logic        in_ready;
  logic        sout;
  logic        busy;

  int checks = 0;
  int errors = 0;

  mtm_alu_serializer dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .C        (C),
    .CTL_in   (CTL_in),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .sout     (sout),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [10:0] frame(input logic t, input logic [7:0] b);
    return {1'b0, t, b, 1'b1};
  endfunction

  // Reference CRC by polynomial long division of {msg, 000} by 1011.
  function automatic logic [2:0] crc_model(input logic [36:0] msg);
    logic [39:0] v;
    v = {msg, 3'b000};
    for (int i = 39; i >= 3; i--) begin
      if (v[i]) v[i -: 4] = v[i -: 4] ^ 4'b1011;
    end
    return v[2:0];
  endfunction

  // Launch one packet and record n serial bits, first bit at bits[54].
  task automatic send_capture(input logic [31:0] c, input logic [7:0] ctl, input int n,
                              input logic [31:0] c_after, input logic [7:0] ctl_after,
                              output logic [54:0] bits, output int busy_cycles);
    int w;
    bits = '0;
    busy_cycles = 0;
    @(negedge clk);
    C = c; CTL_in = ctl; in_valid = 1'b1;
    w = 0;
    while (!in_ready && w < 200) begin
      @(negedge clk);
      w++;
    end
    checks++;
    if (!in_ready) begin
      errors++;
      $display("FAIL accept_timeout: in_ready=%b required 1", in_ready);
    end
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (i == 0) begin
        in_valid = 1'b0; C = c_after; CTL_in = ctl_after;
      end
      bits[54 - i] = sout;
      if (!in_ready) busy_cycles++;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; in_valid = 1'b0; C = '0; CTL_in = '0;
    repeat (3) @(negedge clk);
    checks++;
    if (sout !== 1'b1) begin errors++; $display("FAIL reset_sout: got %b required 1", sout); end
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b required 1", in_ready); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b required 0", busy); end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_result_packet;
    logic [54:0] bits;
    logic [54:0] exp;
    int          bc;
    exp = {frame(1'b0, 8'h12), frame(1'b0, 8'h34), frame(1'b0, 8'h56),
           frame(1'b0, 8'h78), frame(1'b1, 8'h40)};
    send_capture(32'h1234_5678, 8'h40, 55, 32'h1234_5678, 8'h40, bits, bc);
    checks++;
    if (bits !== exp) begin errors++; $display("FAIL result_stream: got %h required %h", bits, exp); end
    checks++;
    if (bc !== 55) begin errors++; $display("FAIL result_busy_cycles: got %0d required 55", bc); end
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || sout !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL result_return_idle: in_ready=%b sout=%b busy=%b required 1 1 0", in_ready, sout, busy);
    end
  endtask

  task automatic test_error_packet;
    logic [54:0] bits;
    int          bc;
    send_capture(32'hDEAD_BEEF, 8'h93, 11, 32'hDEAD_BEEF, 8'h93, bits, bc);
    checks++;
    if (bits[54 -: 11] !== 11'b0_1_1001_0011_1) begin
      errors++; $display("FAIL error_stream: got %b required 01100100111", bits[54 -: 11]);
    end
    checks++;
    if (bc !== 11) begin errors++; $display("FAIL error_busy_cycles: got %0d required 11", bc); end
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || sout !== 1'b1) begin
      errors++; $display("FAIL error_return_idle: in_ready=%b sout=%b required 1 1", in_ready, sout);
    end
  endtask

  task automatic test_back_to_back;
    logic [22:0] bits;
    logic [22:0] exp;
    logic        ready_gap;
    exp = {frame(1'b1, 8'h93), 1'b1, frame(1'b1, 8'h85)};
    ready_gap = 1'b0;
    @(negedge clk);
    C = 32'h0; CTL_in = 8'h93; in_valid = 1'b1;
    for (int i = 0; i < 23; i++) begin
      @(negedge clk);
      if (i == 0) CTL_in = 8'h85;
      bits[22 - i] = sout;
      if (i == 11) ready_gap = in_ready;
    end
    in_valid = 1'b0;
    checks++;
    if (bits !== exp) begin errors++; $display("FAIL b2b_stream: got %b required %b", bits, exp); end
    checks++;
    if (ready_gap !== 1'b1) begin errors++; $display("FAIL b2b_gap_ready: got %b required 1", ready_gap); end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset_mid;
    int bad_bits;
    int w;
    @(negedge clk);
    C = 32'hA5A5_A5A5; CTL_in = 8'h40; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (25) @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL mid_busy_before_reset: got %b required 1", busy); end
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if (sout !== 1'b1 || in_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_idle: sout=%b in_ready=%b busy=%b required 1 1 0", sout, in_ready, busy);
    end
    rst_n = 1'b1;
    bad_bits = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (sout !== 1'b1) bad_bits++;
    end
    checks++;
    if (bad_bits !== 0) begin errors++; $display("FAIL mid_no_residual_bits: got %0d low bits required 0", bad_bits); end

    // Reset dominates in_valid, then acceptance on the first edge after release.
    rst_n = 1'b0; C = 32'h0; CTL_in = 8'h93; in_valid = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || sout !== 1'b1) begin
      errors++; $display("FAIL reset_dominates: in_ready=%b sout=%b required 1 1", in_ready, sout);
    end
    rst_n = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if (sout !== 1'b0 || in_ready !== 1'b0) begin
      errors++; $display("FAIL accept_after_reset: sout=%b in_ready=%b required 0 0", sout, in_ready);
    end
    w = 0;
    while (!in_ready && w < 40) begin
      @(negedge clk);
      w++;
    end
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL post_reset_packet_end: in_ready=%b required 1", in_ready); end
  endtask

  task automatic test_input_change;
    logic [54:0] bits;
    logic [54:0] exp;
    int          bc;
    exp = {frame(1'b0, 8'h00), frame(1'b0, 8'h00), frame(1'b0, 8'h00),
           frame(1'b0, 8'h00), frame(1'b1, 8'h40)};
    send_capture(32'h0, 8'h40, 55, 32'hFFFF_FFFF, 8'hFF, bits, bc);
    checks++;
    if (bits !== exp) begin errors++; $display("FAIL hold_stream: got %h required %h", bits, exp); end
    CTL_in = 8'h00;
    @(negedge clk);
  endtask

  task automatic test_crc;
    logic [54:0] bits;
    logic [7:0]  exp_ctl;
    int          bc;
`ifdef MTM_SER_CRC_REGEN_EN
    exp_ctl = {5'b00100, crc_model({32'h0, 1'b0, 4'b0100})};
`else
    exp_ctl = 8'h27;
`endif
    send_capture(32'h0, 8'h27, 55, 32'h0, 8'h27, bits, bc);
    checks++;
    if (bits[10:0] !== frame(1'b1, exp_ctl)) begin
      errors++; $display("FAIL crc_ctl_frame: got %b required %b", bits[10:0], frame(1'b1, exp_ctl));
    end
    // Error packets are never rewritten.
    send_capture(32'h1234_5678, 8'hA5, 11, 32'h1234_5678, 8'hA5, bits, bc);
    checks++;
    if (bits[54 -: 11] !== frame(1'b1, 8'hA5)) begin
      errors++; $display("FAIL crc_error_untouched: got %b required %b", bits[54 -: 11], frame(1'b1, 8'hA5));
    end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_result_packet();
    test_error_packet();
    test_back_to_back();
    test_reset_mid();
    test_input_change();
    test_crc();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
